// File: rtl/axis_uart_rx.sv
// rtl/axis_uart_rx.sv - UART receive engine with AXI-Stream byte output; optional UART_RX_GLITCH_FILTER_EN majority filter
module axis_uart_rx #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIVIDER_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     uart_rx_i,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     overrun_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    WAIT   = 3'd5
  } uart_state_e;

  // Expected parity bit; odd parity wins when both enables are set.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic odd, input logic even);
    if (odd)       return ~^d;
    else if (even) return ^d;
    else           return 1'b0;
  endfunction

  logic sync1, sync2, rx_s, rx_prev, fall;

  // Two-flop synchronizer, preset to the idle level.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_rx_i;
      sync2 <= sync1;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] hist;
  // Registered 3-sample majority vote so single-cycle glitches never reach the FSM.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hist <= 2'b11;
      rx_s <= 1'b1;
    end else begin
      hist <= {hist[0], sync2};
      rx_s <= (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
    end
  end
`else
  assign rx_s = sync2;
`endif

  // Previous line level for falling-edge detection.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) rx_prev <= 1'b1;
    else          rx_prev <= rx_s;
  end

  assign fall = rx_prev & ~rx_s;

  uart_state_e               state_q, state_d;
  logic [DIVIDER_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d, div_in, div_last, half_last;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      perr_q, perr_d, ferr_q, ferr_d, pend_q, pend_d, commit;

  assign div_in    = (clk_divider_i < DIVIDER_WIDTH'(4)) ? DIVIDER_WIDTH'(4) : clk_divider_i;
  assign div_last  = div_q - DIVIDER_WIDTH'(1);
  assign half_last = (div_q >> 1) - DIVIDER_WIDTH'(1);

  // FSM state and frame datapath registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIVIDER_WIDTH'(4);
      idx_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic: bit timing, sampling and error capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    pend_d  = pend_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (fall || pend_q) begin
          state_d = START;
          cnt_d   = '0;
          div_d   = div_in;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == half_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + DIVIDER_WIDTH'(1);
        end
      end
      DATA: begin
        if (cnt_q == div_last) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s;
          if (idx_q == IDX_W'(DATA_WIDTH - 1))
            state_d = (parity_odd_i || parity_even_i) ? PARITY : STOP;
          else
            idx_d = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + DIVIDER_WIDTH'(1);
        end
      end
      PARITY: begin
        if (cnt_q == div_last) begin
          cnt_d   = '0;
          state_d = STOP;
          if (rx_s != parity_bit(data_q, parity_odd_i, parity_even_i))
            perr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DIVIDER_WIDTH'(1);
        end
      end
      STOP: begin
        if (cnt_q == div_last) begin
          cnt_d   = '0;
          state_d = WAIT;
          if (!rx_s) ferr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DIVIDER_WIDTH'(1);
        end
      end
      WAIT: begin
        commit  = 1'b1;
        state_d = IDLE;
        // An edge seen here would be lost by rx_prev; remember it for IDLE.
        if (fall) pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: load on commit when free, otherwise drop and flag overrun.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_axis_tdata_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      parity_err_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      if (m_axis_tvalid_o && m_axis_tready_i) m_axis_tvalid_o <= 1'b0;
      if (commit) begin
        parity_err_o <= perr_q;
        frame_err_o  <= ferr_q;
        if (!m_axis_tvalid_o || m_axis_tready_i) begin
          m_axis_tdata_o  <= data_q;
          m_axis_tvalid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_rx.sv
// tb/tb_axis_uart_rx.sv - directed self-checking bench for axis_uart_rx
module tb_axis_uart_rx;

  logic        clk = 1'b0;
  logic        arstn;
  logic [31:0] divider;
  logic        podd, peven, rx, tready;
  logic [7:0]  tdata;
  logic        tvalid, perr, ferr, ovr;

  int n_vec = 0;
  int n_err = 0;
  int beats = 0;
  int perr_n = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  logic [7:0] last_data = 8'h00;
  int bit_len = 16;
  int b0, p0, f0, o0;

  always #5 clk = ~clk;

  axis_uart_rx dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .clk_divider_i   (divider),
    .parity_odd_i    (podd),
    .parity_even_i   (peven),
    .uart_rx_i       (rx),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .parity_err_o    (perr),
    .frame_err_o     (ferr),
    .overrun_o       (ovr)
  );

  // Observe handshakes and pulses away from the active edge.
  always @(negedge clk) begin
    if (tvalid && tready) begin
      beats = beats + 1;
      last_data = tdata;
    end
    if (perr) perr_n = perr_n + 1;
    if (ferr) ferr_n = ferr_n + 1;
    if (ovr)  ovr_n  = ovr_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b0 = beats; p0 = perr_n; f0 = ferr_n; o0 = ovr_n;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (bit_len) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par,
                            input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par);
    drive_bit(stop);
    rx = 1'b1;
    repeat (bit_len + 8) @(posedge clk);
    #1;
  endtask

  initial begin
    arstn = 1'b0; divider = 32'd16; podd = 1'b0; peven = 1'b0;
    rx = 1'b1; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata",  32'(tdata),  32'd0);
    check("rst_perr",   32'(perr),   32'd0);
    check("rst_ferr",   32'(ferr),   32'd0);
    check("rst_ovr",    32'(ovr),    32'd0);
    arstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Plain 8N1 frame
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_beats", 32'(beats - b0), 32'd1);
    check("a5_data",  32'(last_data),  32'hA5);
    check("a5_perr",  32'(perr_n - p0), 32'd0);
    check("a5_ferr",  32'(ferr_n - f0), 32'd0);
    check("a5_ovr",   32'(ovr_n - o0),  32'd0);
    check("a5_idle",  32'(tvalid),      32'd0);

    // Even parity: 0xA5 has four ones, so parity bit 0 is correct
    peven = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check("even_ok_beats", 32'(beats - b0),  32'd1);
    check("even_ok_data",  32'(last_data),   32'hA5);
    check("even_ok_perr",  32'(perr_n - p0), 32'd0);
    snap();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check("even_bad_beats", 32'(beats - b0),  32'd1);
    check("even_bad_data",  32'(last_data),   32'hA5);
    check("even_bad_perr",  32'(perr_n - p0), 32'd1);

    // Both enables: odd wins; 0x01 has one 1 so parity bit 0 is correct
    podd = 1'b1;
    snap();
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    check("odd_pri_data", 32'(last_data),   32'h01);
    check("odd_pri_perr", 32'(perr_n - p0), 32'd0);
    podd = 1'b0; peven = 1'b0;

    // Framing error still delivers the byte; next frame is clean
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse", 32'(ferr_n - f0), 32'd1);
    check("ferr_data",  32'(last_data),   32'h3C);
    check("ferr_beats", 32'(beats - b0),  32'd1);
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("after_ferr_data",  32'(last_data),   32'h5A);
    check("after_ferr_ferr",  32'(ferr_n - f0), 32'd0);
    check("after_ferr_beats", 32'(beats - b0),  32'd1);

    // Overrun with a stalled sink
    tready = 1'b0;
    snap();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    check("ovr_first_valid", 32'(tvalid), 32'd1);
    check("ovr_first_data",  32'(tdata),  32'h11);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_pulse",  32'(ovr_n - o0), 32'd1);
    check("ovr_hold",   32'(tdata),      32'h11);
    check("ovr_valid",  32'(tvalid),     32'd1);
    tready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("ovr_beats", 32'(beats - b0), 32'd1);
    check("ovr_data",  32'(last_data),  32'h11);
    check("ovr_drain", 32'(tvalid),     32'd0);

    // Short low pulse is a false start
    snap();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (48) @(posedge clk);
    #1;
    check("glitch_beats", 32'(beats - b0), 32'd0);
    check("glitch_valid", 32'(tvalid), 32'd0);
    check("glitch_pulses", 32'((perr_n - p0) + (ferr_n - f0) + (ovr_n - o0)), 32'd0);

    // Reset mid-DATA drops the partial frame
    snap();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    arstn = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_valid", 32'(tvalid), 32'd0);
    check("midrst_data",  32'(tdata),  32'd0);
    arstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_beats", 32'(beats - b0), 32'd0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    check("post_rst_beats", 32'(beats - b0), 32'd1);
    check("post_rst_data",  32'(last_data),  32'h7E);
    check("post_rst_pulses", 32'((perr_n - p0) + (ferr_n - f0) + (ovr_n - o0)), 32'd0);

    // Divider below 4 is clamped to 4 cycles per bit
    divider = 32'd2;
    bit_len = 4;
    snap();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    check("div_min_beats", 32'(beats - b0), 32'd1);
    check("div_min_data",  32'(last_data),  32'hC3);
    check("div_min_ferr",  32'(ferr_n - f0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
